// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - control bundle between cpu_controller and the datapath, memory and PC logic
//
// Purpose: gathers the instruction/status inputs and every control output of
// the Simple RISC Machine controller into one bundle.
//   master modport : cpu_controller (consumes ir, Z_out; drives all controls)
//   slave  modport : datapath / memory / PC side
// Signals:
//   ir[15:0]        instruction register contents
//   Z_out[2:0]      status flags {overflow, negative, zero}
//   vsel[1:0]       register-file write-data select
//   writenum/readnum register numbers
//   write, loada, loadb, loadc, loads, asel, bsel  datapath controls
//   shift[1:0], ALUop[1:0]  shifter and ALU ops
//   sximm5/sximm8   sign-extended immediates
//   mem_cmd[1:0], addr_sel  memory command and address source
//   load_ir, load_addr, load_pc, reset_pc, pc_sel[1:0]  IR/address/PC controls
//   halted          high while halted
interface cpu_controller_if;
  logic [15:0] ir;
  logic [2:0]  Z_out;
  logic [1:0]  vsel;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic [1:0]  mem_cmd;
  logic        addr_sel;
  logic        load_ir;
  logic        load_addr;
  logic        load_pc;
  logic        reset_pc;
  logic [1:0]  pc_sel;
  logic        halted;

  modport master (
    input  ir, Z_out,
    output vsel, writenum, readnum, write, loada, loadb, loadc, loads, asel, bsel,
           shift, ALUop, sximm5, sximm8, mem_cmd, addr_sel, load_ir, load_addr,
           load_pc, reset_pc, pc_sel, halted
  );

  modport slave (
    output ir, Z_out,
    input  vsel, writenum, readnum, write, loada, loadb, loadc, loads, asel, bsel,
           shift, ALUop, sximm5, sximm8, mem_cmd, addr_sel, load_ir, load_addr,
           load_pc, reset_pc, pc_sel, halted
  );
endinterface

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Moore FSM sequencing fetch, decode and execute of the Simple RISC Machine
//
// Purpose: fetches each instruction, decodes ir and drives every datapath,
// memory and PC control; evaluates branch conditions from Z_out in DECODE.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (forces the RESET state at once)
//   bus      cpu_controller_if.master: ir/Z_out in, all control outputs out
// Control outputs are registered: each edge loads the output pattern of the
// state being entered, so they depend only on the state register and ir.
module cpu_controller (
  input  logic             clk,
  input  logic             reset_n,
  cpu_controller_if.master bus
);

  localparam logic [2:0] LINK_REG = 3'd7;

  // {opcode, op} encodings
  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_REG = 5'b110_00;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;
  localparam logic [4:0] I_MVN     = 5'b101_11;
  localparam logic [4:0] I_LDR     = 5'b011_00;
  localparam logic [4:0] I_STR     = 5'b100_00;
  localparam logic [4:0] I_B       = 5'b001_00;
  localparam logic [4:0] I_BX      = 5'b010_00;
  localparam logic [4:0] I_BLX     = 5'b010_10;
  localparam logic [4:0] I_BL      = 5'b010_11;
  localparam logic [4:0] I_HALT    = 5'b111_00;

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
    S_WRITE_IMM, S_GET_A, S_GET_B, S_CALC, S_WRITE_REG,
    S_CALC_ADDR, S_LOAD_ADDR, S_MEM_RD, S_WRITE_MEM,
    S_GET_RD, S_MOVE_B, S_MEM_WR,
    S_BRANCH, S_WRITE_LR, S_LOAD_PC_REG, S_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] vsel;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
    logic [1:0] mem_cmd;
    logic       addr_sel;
    logic       load_ir;
    logic       load_addr;
    logic       load_pc;
    logic       reset_pc;
    logic [1:0] pc_sel;
    logic       halted;
  } ctrl_t;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  ctrl_t  ctrl_nxt;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [4:0] ins;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [2:0] rm;
  logic [2:0] cond;
  logic       zf;
  logic       nf;
  logic       vf;
  logic       cond_true;

  assign opcode = bus.ir[15:13];
  assign op     = bus.ir[12:11];
  assign ins    = {opcode, op};
  assign rn     = bus.ir[10:8];
  assign rd     = bus.ir[7:5];
  assign rm     = bus.ir[2:0];
  assign cond   = bus.ir[10:8];

  assign zf = bus.Z_out[0];
  assign nf = bus.Z_out[1];
  assign vf = bus.Z_out[2];

  // Branch condition; undefined cond codes are never taken.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = zf;
      3'b010:  cond_true = ~zf;
      3'b011:  cond_true = nf ^ vf;
      3'b100:  cond_true = (nf ^ vf) | zf;
      default: cond_true = 1'b0;
    endcase
  end

  // Next state. Multi-instruction states (GET_A, CALC, LOAD_ADDR, MOVE_B,
  // WRITE_LR) pick their successor from ir, which is held stable until the
  // next IF2.
  always_comb begin
    state_nxt = S_IF1;
    case (state)
      S_RESET:     state_nxt = S_IF1;
      S_IF1:       state_nxt = S_IF2;
      S_IF2:       state_nxt = S_UPDATE_PC;
      S_UPDATE_PC: state_nxt = S_DECODE;
      S_DECODE: begin
        case (ins)
          I_MOV_IMM:                           state_nxt = S_WRITE_IMM;
          I_MOV_REG, I_MVN:                    state_nxt = S_GET_B;
          I_ADD, I_AND, I_CMP, I_LDR, I_STR:   state_nxt = S_GET_A;
          I_B:                                 state_nxt = cond_true ? S_BRANCH : S_IF1;
          I_BL, I_BLX:                         state_nxt = S_WRITE_LR;
          I_BX:                                state_nxt = S_GET_RD;
          I_HALT:                              state_nxt = S_HALT;
          default:                             state_nxt = S_IF1;
        endcase
      end
      S_GET_A:       state_nxt = (opcode == 3'b101) ? S_GET_B : S_CALC_ADDR;
      S_GET_B:       state_nxt = S_CALC;
      S_CALC:        state_nxt = (ins == I_CMP) ? S_IF1 : S_WRITE_REG;
      S_CALC_ADDR:   state_nxt = S_LOAD_ADDR;
      S_LOAD_ADDR:   state_nxt = (ins == I_LDR) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD:      state_nxt = S_WRITE_MEM;
      S_GET_RD:      state_nxt = S_MOVE_B;
      S_MOVE_B:      state_nxt = (ins == I_STR) ? S_MEM_WR : S_LOAD_PC_REG;
      S_WRITE_LR:    state_nxt = (ins == I_BL) ? S_BRANCH : S_GET_RD;
      S_HALT:        state_nxt = S_HALT;
      default:       state_nxt = S_IF1;
    endcase
  end

  // Output pattern of the state about to be entered.
  always_comb begin
    ctrl_nxt = '0;
    case (state_nxt)
      S_RESET: begin
        ctrl_nxt.reset_pc = 1'b1;
        ctrl_nxt.load_pc  = 1'b1;
      end
      S_IF1: begin
        ctrl_nxt.addr_sel = 1'b1;
        ctrl_nxt.mem_cmd  = 2'b01;
      end
      S_IF2: begin
        ctrl_nxt.addr_sel = 1'b1;
        ctrl_nxt.mem_cmd  = 2'b01;
        ctrl_nxt.load_ir  = 1'b1;
      end
      S_UPDATE_PC: begin
        ctrl_nxt.load_pc = 1'b1;
        ctrl_nxt.pc_sel  = 2'b00;
      end
      S_WRITE_IMM: begin
        ctrl_nxt.vsel     = 2'b10;
        ctrl_nxt.writenum = rn;
        ctrl_nxt.write    = 1'b1;
      end
      S_GET_A: begin
        ctrl_nxt.readnum = rn;
        ctrl_nxt.loada   = 1'b1;
      end
      S_GET_B: begin
        ctrl_nxt.readnum = rm;
        ctrl_nxt.loadb   = 1'b1;
      end
      S_CALC: begin
        ctrl_nxt.shift = bus.ir[4:3];
        case (ins)
          I_MOV_REG: begin
            ctrl_nxt.asel   = 1'b1;
            ctrl_nxt.alu_op = 2'b00;
            ctrl_nxt.loadc  = 1'b1;
          end
          I_MVN: begin
            ctrl_nxt.alu_op = 2'b11;
            ctrl_nxt.loadc  = 1'b1;
          end
          I_CMP: begin
            // Only the status register is updated; C is left untouched.
            ctrl_nxt.alu_op = 2'b01;
            ctrl_nxt.loads  = 1'b1;
          end
          default: begin
            ctrl_nxt.alu_op = op;
            ctrl_nxt.loadc  = 1'b1;
          end
        endcase
      end
      S_WRITE_REG: begin
        ctrl_nxt.vsel     = 2'b00;
        ctrl_nxt.writenum = rd;
        ctrl_nxt.write    = 1'b1;
      end
      S_CALC_ADDR: begin
        ctrl_nxt.bsel   = 1'b1;
        ctrl_nxt.alu_op = 2'b00;
        ctrl_nxt.loadc  = 1'b1;
      end
      S_LOAD_ADDR: ctrl_nxt.load_addr = 1'b1;
      S_MEM_RD: begin
        ctrl_nxt.addr_sel = 1'b0;
        ctrl_nxt.mem_cmd  = 2'b01;
      end
      S_WRITE_MEM: begin
        ctrl_nxt.addr_sel = 1'b0;
        ctrl_nxt.mem_cmd  = 2'b01;
        ctrl_nxt.vsel     = 2'b11;
        ctrl_nxt.writenum = rd;
        ctrl_nxt.write    = 1'b1;
      end
      S_GET_RD: begin
        ctrl_nxt.readnum = rd;
        ctrl_nxt.loadb   = 1'b1;
      end
      S_MOVE_B: begin
        ctrl_nxt.asel   = 1'b1;
        ctrl_nxt.alu_op = 2'b00;
        ctrl_nxt.loadc  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_nxt.addr_sel = 1'b0;
        ctrl_nxt.mem_cmd  = 2'b10;
      end
      S_BRANCH: begin
        ctrl_nxt.load_pc = 1'b1;
        ctrl_nxt.pc_sel  = 2'b01;
      end
      S_WRITE_LR: begin
        // PC already holds the incremented address from UPDATE_PC.
        ctrl_nxt.vsel     = 2'b01;
        ctrl_nxt.writenum = LINK_REG;
        ctrl_nxt.write    = 1'b1;
      end
      S_LOAD_PC_REG: begin
        ctrl_nxt.load_pc = 1'b1;
        ctrl_nxt.pc_sel  = 2'b10;
      end
      S_HALT: ctrl_nxt.halted = 1'b1;
      default: ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_RESET;
      ctrl             <= '0;
      ctrl.reset_pc    <= 1'b1;
      ctrl.load_pc     <= 1'b1;
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_nxt;
    end
  end

  assign bus.vsel      = ctrl.vsel;
  assign bus.writenum  = ctrl.writenum;
  assign bus.readnum   = ctrl.readnum;
  assign bus.write     = ctrl.write;
  assign bus.loada     = ctrl.loada;
  assign bus.loadb     = ctrl.loadb;
  assign bus.loadc     = ctrl.loadc;
  assign bus.loads     = ctrl.loads;
  assign bus.asel      = ctrl.asel;
  assign bus.bsel      = ctrl.bsel;
  assign bus.shift     = ctrl.shift;
  assign bus.ALUop     = ctrl.alu_op;
  assign bus.mem_cmd   = ctrl.mem_cmd;
  assign bus.addr_sel  = ctrl.addr_sel;
  assign bus.load_ir   = ctrl.load_ir;
  assign bus.load_addr = ctrl.load_addr;
  assign bus.load_pc   = ctrl.load_pc;
  assign bus.reset_pc  = ctrl.reset_pc;
  assign bus.pc_sel    = ctrl.pc_sel;
  assign bus.halted    = ctrl.halted;

  assign bus.sximm5 = {{11{bus.ir[4]}}, bus.ir[4:0]};
  assign bus.sximm8 = {{8{bus.ir[7]}}, bus.ir[7:0]};

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Moore state machine that sequences the Simple RISC Machine datapath. It fetches each instruction, decodes the instruction register, and drives every datapath control input (register-file mux select, register numbers, pipeline load enables, shift, operand selects, ALU op, status load). It also drives the memory command and program-counter controls, and evaluates branch conditions from the 3-bit status flags the datapath returns. It sits between the instruction register, memory and PC logic on one side and the datapath on the other.

## Interface
- LINK_REG, 3'd7: register written with the return address by BL/BLX.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ir  in  16  current instruction-register contents
- Z_out  in  3  status flags: [0] zero, [1] negative, [2] overflow
- vsel  out  2  register-file write-data select: 00 datapath_out, 01 PC, 10 sximm8, 11 mdata
- writenum, readnum  out  3 each  register numbers
- write, loada, loadb, loadc, loads, asel, bsel  out  1 each  datapath controls
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm5  out  16  sign-extended ir[4:0]
- sximm8  out  16  sign-extended ir[7:0]
- mem_cmd  out  2  memory command: 00 none, 01 read, 10 write
- addr_sel  out  1  1 = memory address from PC, 0 = from data address register
- load_ir, load_addr, load_pc, reset_pc  out  1 each  enables for the instruction, address and PC registers
- pc_sel  out  2  next-PC select: 00 PC+1, 01 PC+sximm8, 10 datapath_out
- halted  out  1  high while in HALT

## Operation
- Field decode: opcode = ir[15:13], op = ir[12:11], Rn = ir[10:8], Rd = ir[7:5], Rm = ir[2:0], cond = ir[10:8].
- Outputs are a pure function of the state register and ir. Every control output is 0 in any state that does not name it.
- `shift` = ir[4:3` in ALU and register-MOV states. It is forced to 00 for LDR, STR and BX.
- Fetch sequence: RESET → IF1 → IF2 → UPDATE_PC → DECODE.
  - RESET: reset_pc=1, load_pc=1.
  - IF1: addr_sel=1, mem_cmd=01.
  - IF2: addr_sel=1, mem_cmd=01, load_ir=1.
  - UPDATE_PC: load_pc=1, pc_sel=00.
- Paths out of DECODE:
  - MOV Rn,#im8 (110/10): WRITE_IMM (vsel=10, writenum=Rn, write=1).
  - MOV Rd,Rm (110/00): GET_B (readnum=Rm, loadb=1) → CALC (asel=1, ALUop=00, loadc=1) → WRITE_REG (vsel=00, writenum=Rd, write=1).
  - ADD/AND (101/00, 101/10): GET_A (readnum=Rn, loada=1) → GET_B → CALC (ALUop=op, loadc=1) → WRITE_REG.
  - MVN (101/11): GET_B → CALC (ALUop=11, loadc=1) → WRITE_REG.
  - CMP (101/01): GET_A → GET_B → CALC (ALUop=01, loads=1, loadc=0). CMP never writes a register.
  - LDR (011/00): GET_A → CALC_ADDR (bsel=1, ALUop=00, loadc=1) → LOAD_ADDR (load_addr=1) → MEM_RD (addr_sel=0, mem_cmd=01) → WRITE_MEM (addr_sel=0, mem_cmd=01, vsel=11, writenum=Rd, write=1).
  - STR (100/00): GET_A → CALC_ADDR → LOAD_ADDR → GET_RD (readnum=Rd, loadb=1) → MOVE_B (asel=1, ALUop=00, loadc=1) → MEM_WR (addr_sel=0, mem_cmd=10).
  - B (001/00): if the condition holds → BRANCH (load_pc=1, pc_sel=01).
    - Conditions: cond 000 always; 001 Z; 010 !Z; 011 N≠V; 100 (N≠V)|Z.
    - Any other cond value is never taken.
  - BL (010/11): WRITE_LR (vsel=01, writenum=LINK_REG, write=1) → BRANCH.
  - BX (010/00): GET_RD → MOVE_B → LOAD_PC_REG (load_pc=1, pc_sel=10).
  - BLX (010/10): WRITE_LR → GET_RD → MOVE_B → LOAD_PC_REG.
  - HALT (111/00): HALT. halted=1 and mem_cmd=00; the state is held until reset.
  - Any other encoding, and a B whose condition is false: DECODE → IF1 (NOP).
- Every terminal state (WRITE_IMM, WRITE_REG, CMP's CALC, WRITE_MEM, MEM_WR, BRANCH, LOAD_PC_REG) → IF1.
- The PC used by BRANCH and WRITE_LR is already incremented in UPDATE_PC.

## Timing
- reset_n low: state = RESET immediately (asynchronous); outputs settle to RESET values. Reset mid-instruction aborts it with no further writes.
- First clk edge with reset_n high: RESET → IF1.
- Memory read data is valid in the cycle after the read command is issued. ir and mdata are sampled on the edge ending IF2 and WRITE_MEM respectively.
- Cycles per instruction, IF1 through the terminal state inclusive:
  - MOV imm 5; B not taken / NOP 4; B taken 5
  - MOV reg and MVN 7; CMP 7; ADD/AND 8
  - LDR 9; STR 10
  - BL 6; BX 7; BLX 8
- Z_out is sampled combinationally in DECODE. A CMP immediately followed by a branch must see the flags updated by CMP's CALC edge.
- ir must remain stable from the end of IF2 until the next IF2.

## Test plan
- Reset mid-operation: drop reset_n during CALC of ADD → all outputs except reset_pc/load_pc equal 0 within the same cycle. After release, exactly one RESET cycle, then IF1 (addr_sel=1, mem_cmd=01).
- ir=16'hD007 (MOV R0,#7) → DECODE, then one cycle with vsel=10, writenum=0, write=1, then IF1; 5 cycles total.
- ir=16'hA148 (ADD R2,R1,R0,LSL#1) → sequence:
  - readnum=1, loada=1
  - readnum=0, loadb=1
  - ALUop=00, shift=01, loadc=1
  - writenum=2, vsel=00, write=1
- ir=16'hA900 (CMP R1,R0) → loads=1 for one cycle; write=0 throughout; back to IF1 after 7 cycles.
- ir=16'h2103 (BEQ +3) with Z_out=3'b001 → BRANCH with load_pc=1, pc_sel=01. Same ir with Z_out=3'b000 → DECODE goes directly to IF1, and load_pc is never asserted outside UPDATE_PC.
- ir=16'hE000 (HALT) → halted=1 and mem_cmd=00 for 20+ cycles. Pulse reset_n low → halted=0 and fetch restarts.
